rev_alu_pipe: RTL and testbench

//  Parametrised, pipelined successor to the 8-bit reversible ALU: WIDTH-bit datapath built from a chain
//  of reversible full-adder cells plus a logic unit, wrapped in a 2-stage valid/ready pipeline.

---
 rtl/rev_alu_pkg.sv | 17 +
 rtl/rev_full_adder.sv | 19 +
 rtl/rev_alu_pipe.sv | 156 +++++++++++++++
 tb/tb_rev_alu_pipe.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rev_alu_pkg.sv
// Shared opcode encodings and decode helpers for the reversible ALU pipeline.
package rev_alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_ADC  = 3'b010;
    localparam logic [2:0] OP_SBB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_NOTA = 3'b111;

    function automatic logic is_arith(input logic [2:0] sel);
        return ~sel[2];
    endfunction

endpackage

// File: rtl/rev_full_adder.sv
// Reversible full-adder cell: (p,q,r,s) -> (p^r, q, p^q^r, maj(p,q,r)^s).
// With s tied low, c is the sum bit and d is the carry out.
module rev_full_adder (
    input  logic p,
    input  logic q,
    input  logic r,
    input  logic s,
    output logic a,
    output logic b,
    output logic c,
    output logic d
);

    assign a = p ^ r;
    assign b = q;
    assign c = p ^ q ^ r;
    assign d = ((p & q) | (q & r) | (p & r)) ^ s;

endmodule

// File: rtl/rev_alu_pipe.sv
// Two-stage valid/ready ALU built on a ripple chain of reversible full-adder cells.
// Define REV_GARBAGE_EN to expose the registered adder garbage outputs on GARBAGE.
module rev_alu_pipe
    import rev_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    input  logic [2:0]       SEL,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] RESULT,
    output logic             COUT,
    output logic             ZERO,
    output logic             NEG,
    output logic             OVF
`ifdef REV_GARBAGE_EN
    ,
    output logic [2*WIDTH-1:0] GARBAGE
`endif
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_q;
    logic             s1_cin;
    logic [2:0]       s1_sel;

    logic             s2_adv;
    logic             s1_adv;

    logic [WIDTH-1:0] q_in;
    logic             cin_in;

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    logic [WIDTH-1:0] res_d;
    logic             c_d;
    logic             v_d;

    assign s2_adv   = !OUT_VALID || OUT_READY;
    assign s1_adv   = !s1_valid || s2_adv;
    assign IN_READY = s1_adv;

    // Subtracting ops feed the inverted B into the chain; logic ops reuse q as plain B.
    assign q_in = (is_arith(SEL) && SEL[0]) ? ~B : B;

    always_comb begin
        cin_in = 1'b0;
        case (SEL)
            OP_SUB:         cin_in = 1'b1;
            OP_ADC, OP_SBB: cin_in = CIN;
            default:        cin_in = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_q     <= '0;
            s1_cin   <= 1'b0;
            s1_sel   <= OP_ADD;
        end else if (s1_adv) begin
            s1_valid <= IN_VALID;
            if (IN_VALID) begin
                s1_a   <= A;
                s1_q   <= q_in;
                s1_cin <= cin_in;
                s1_sel <= SEL;
            end
        end
    end

    assign carry[0] = s1_cin;

`ifdef REV_GARBAGE_EN
    logic [WIDTH-1:0]   pr_vec;
    logic [WIDTH-1:0]   q_vec;
    logic [2*WIDTH-1:0] garbage_d;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        rev_full_adder u_cell (
            .p (s1_a[i]),
            .q (s1_q[i]),
            .r (carry[i]),
            .s (1'b0),
`ifdef REV_GARBAGE_EN
            .a (pr_vec[i]),
            .b (q_vec[i]),
`else
            .a (),
            .b (),
`endif
            .c (sum[i]),
            .d (carry[i+1])
        );
    end

    always_comb begin
        res_d = '0;
        c_d   = 1'b0;
        v_d   = 1'b0;
        case (s1_sel)
            OP_AND:  res_d = s1_a & s1_q;
            OP_OR:   res_d = s1_a | s1_q;
            OP_XOR:  res_d = s1_a ^ s1_q;
            OP_NOTA: res_d = ~s1_a;
            default: begin
                res_d = sum;
                c_d   = carry[WIDTH];
                v_d   = (s1_a[WIDTH-1] == s1_q[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
            end
        endcase
    end

`ifdef REV_GARBAGE_EN
    assign garbage_d = is_arith(s1_sel) ? {q_vec, pr_vec} : '0;
`endif

    // Outputs only reload when a real beat moves into S2, so bubbles never disturb them.
    always_ff @(posedge CLK) begin
        if (RST) begin
            OUT_VALID <= 1'b0;
            RESULT    <= '0;
            COUT      <= 1'b0;
            ZERO      <= 1'b0;
            NEG       <= 1'b0;
            OVF       <= 1'b0;
`ifdef REV_GARBAGE_EN
            GARBAGE   <= '0;
`endif
        end else if (s2_adv) begin
            OUT_VALID <= s1_valid;
            if (s1_valid) begin
                RESULT  <= res_d;
                COUT    <= c_d;
                ZERO    <= (res_d == '0);
                NEG     <= res_d[WIDTH-1];
                OVF     <= v_d;
`ifdef REV_GARBAGE_EN
                GARBAGE <= garbage_d;
`endif
            end
        end
    end

endmodule

// File: tb/tb_rev_alu_pipe.sv
// Scoreboard bench for rev_alu_pipe: driver pushes hand-computed results, monitor pops on output.
module tb_rev_alu_pipe;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [7:0]  A = '0;
    logic [7:0]  B = '0;
    logic        CIN = 1'b0;
    logic [2:0]  SEL = '0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b1;
    logic [7:0]  RESULT;
    logic        COUT;
    logic        ZERO;
    logic        NEG;
    logic        OVF;
`ifdef REV_GARBAGE_EN
    logic [15:0] GARBAGE;
`endif

    rev_alu_pipe #(.WIDTH(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .CIN       (CIN),
        .SEL       (SEL),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .RESULT    (RESULT),
        .COUT      (COUT),
        .ZERO      (ZERO),
        .NEG       (NEG),
        .OVF       (OVF)
`ifdef REV_GARBAGE_EN
        ,
        .GARBAGE   (GARBAGE)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]  res;
        logic        c;
        logic        z;
        logic        n;
        logic        v;
        logic        gchk;
        logic [15:0] garb;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: the handshake seen at a negedge completes on the following posedge.
    always @(negedge CLK) begin
        if (!RST && OUT_VALID && OUT_READY) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'(RESULT), 32'hDEAD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, ".result"}, 32'(RESULT), 32'(e.res));
                check({e.name, ".flags"}, {28'd0, COUT, ZERO, NEG, OVF},
                      {28'd0, e.c, e.z, e.n, e.v});
`ifdef REV_GARBAGE_EN
                if (e.gchk) check({e.name, ".garbage"}, 32'(GARBAGE), 32'(e.garb));
`endif
            end
        end
    end

    task automatic send(input string name, input logic [2:0] sel, input logic [7:0] a,
                        input logic [7:0] b, input logic cin, input logic [7:0] res,
                        input logic c, input logic z, input logic n, input logic v,
                        input logic gchk, input logic [15:0] garb);
        exp_t e;
        bit   accepted;
        e.res = res; e.c = c; e.z = z; e.n = n; e.v = v;
        e.gchk = gchk; e.garb = garb; e.name = name;
        @(posedge CLK); #1;
        A = a; B = b; CIN = cin; SEL = sel; IN_VALID = 1'b1;
        accepted = 0;
        for (int k = 0; k < 60 && !accepted; k++) begin
            @(negedge CLK);
            if (IN_READY) begin
                exp_q.push_back(e);
                accepted = 1;
            end
        end
        checks++;
        if (!accepted) begin
            errors++;
            $display("FAIL %s.accept: got IN_READY=0 for 60 cycles expected acceptance", name);
        end
    endtask

    task automatic idle();
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(posedge CLK);
            k++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".out_valid"}, 32'(OUT_VALID), 32'd0);
        check({tag, ".result"}, 32'(RESULT), 32'd0);
        check({tag, ".flags"}, {28'd0, COUT, ZERO, NEG, OVF}, 32'd0);
        check({tag, ".in_ready"}, 32'(IN_READY), 32'd1);
`ifdef REV_GARBAGE_EN
        check({tag, ".garbage"}, 32'(GARBAGE), 32'd0);
`endif
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check_reset_outputs("reset");

        // Arithmetic and logic vectors, full throughput.
        send("add_ff_01",  3'b000, 8'hFF, 8'h01, 1'b0, 8'h00, 1, 1, 0, 0, 0, 16'h0);
        send("sub_80_01",  3'b001, 8'h80, 8'h01, 1'b0, 8'h7F, 1, 0, 0, 1, 0, 16'h0);
        send("sbb_00_00",  3'b011, 8'h00, 8'h00, 1'b0, 8'hFF, 0, 0, 1, 0, 0, 16'h0);
        send("nota_0f",    3'b111, 8'h0F, 8'h00, 1'b0, 8'hF0, 0, 0, 1, 0, 0, 16'h0);
        send("xor_aa_aa",  3'b110, 8'hAA, 8'hAA, 1'b0, 8'h00, 0, 1, 0, 0, 0, 16'h0);
        send("add_7f_01",  3'b000, 8'h7F, 8'h01, 1'b1, 8'h80, 0, 0, 1, 1, 0, 16'h0);
        send("adc_10_20",  3'b010, 8'h10, 8'h20, 1'b1, 8'h31, 0, 0, 0, 0, 0, 16'h0);
        send("sub_05_05",  3'b001, 8'h05, 8'h05, 1'b0, 8'h00, 1, 1, 0, 0, 0, 16'h0);
        send("or_f0_0f",   3'b101, 8'hF0, 8'h0F, 1'b1, 8'hFF, 0, 0, 1, 0, 0, 16'h0);
        send("and_cc_aa",  3'b100, 8'hCC, 8'hAA, 1'b0, 8'h88, 0, 0, 1, 0, 0, 16'h0);
        send("add_03_01",  3'b000, 8'h03, 8'h01, 1'b0, 8'h04, 0, 0, 0, 0, 1, 16'h0105);
        send("and_ff_0f",  3'b100, 8'hFF, 8'h0F, 1'b0, 8'h0F, 0, 0, 0, 0, 1, 16'h0000);
        idle();
        drain();

        // Backpressure: two beats fill the pipe, the third waits for OUT_READY.
        @(posedge CLK); #1 OUT_READY = 1'b0;
        fork
            begin
                send("stall_b1", 3'b000, 8'h01, 8'h01, 1'b0, 8'h02, 0, 0, 0, 0, 0, 16'h0);
                send("stall_b2", 3'b000, 8'h02, 8'h02, 1'b0, 8'h04, 0, 0, 0, 0, 0, 16'h0);
                send("stall_b3", 3'b000, 8'h03, 8'h03, 1'b0, 8'h06, 0, 0, 0, 0, 0, 16'h0);
                idle();
            end
            begin
                repeat (5) @(posedge CLK);
                @(negedge CLK);
                check("stall.in_ready_low", 32'(IN_READY), 32'd0);
                check("stall.out_valid", 32'(OUT_VALID), 32'd1);
                check("stall.result_a", 32'(RESULT), 32'h02);
                repeat (3) @(negedge CLK);
                check("stall.result_b", 32'(RESULT), 32'h02);
                check("stall.queue_depth", 32'(exp_q.size()), 32'd2);
                @(posedge CLK); #1 OUT_READY = 1'b1;
                @(negedge CLK);
                check("stall.in_ready_on_release", 32'(IN_READY), 32'd1);
            end
        join
        drain();

        // Reset with two beats in flight: both must vanish.
        @(posedge CLK); #1 OUT_READY = 1'b0;
        send("rst_b1", 3'b000, 8'h11, 8'h11, 1'b0, 8'h22, 0, 0, 0, 0, 0, 16'h0);
        send("rst_b2", 3'b000, 8'h12, 8'h12, 1'b0, 8'h24, 0, 0, 0, 0, 0, 16'h0);
        idle();
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        exp_q.delete();
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        check_reset_outputs("midrst");
        OUT_READY = 1'b1;
        repeat (5) @(posedge CLK);
        send("post_rst", 3'b001, 8'h05, 8'h05, 1'b0, 8'h00, 1, 1, 0, 0, 0, 16'h0);
        idle();
        drain();

        repeat (3) @(posedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
